conv_out_writer: RTL and testbench
==================================

Name: conv_out_writer

Overview:
- Consumer end of the convolution output-start handshake.
- Latches the output-volume parameters on the start pulse (set_out_params), then walks the output buffer. Order: rows within a channel group, then channel groups.
- Issues one write-burst request per row over a valid/ready interface to the output memory port.
- On the final accepted burst, pulses done, which drives the upstream reset_isOnOutput.

Parameters:
ADDR_W 32 memory address width (mem_addr_t)
W_W 12 output row width in words (out_width_t)
H_W 12 row-count-minus-one width (width_t)
GAP_W 16 row address stride width (output_gap_t)
FRAME_W 24 frame size width (outframe_addr_t)
CG_W 8 channel-group index width (cg_addr_t)

Ports:
clock input 1 clock
resetN input 1 synchronous active-low reset
start input 1 single-cycle parameter-load pulse (set_out_params)
last_volume input 1 sampled with start; marks last output volume (set_LastOutput)
output_addr input ADDR_W first row address of group 0
frame_start input ADDR_W base of group 0 frame
out_w input W_W burst length per row, in words
buf_h1 input H_W rows per group minus 1
addr_gap input GAP_W address step between rows
frame_size input FRAME_W address step between channel-group frames
idx_max input CG_W last channel-group index (inclusive)
do_upsample input 1 row-duplication request (used only with CONV_OUT_UPSAMPLE_EN)
wr_ready input 1 memory accepts current burst
busy output 1 high from the cycle after an accepted start through the done cycle
wr_valid output 1 burst request valid
wr_addr output ADDR_W burst start address
wr_len output W_W burst length (latched out_w)
wr_cg output CG_W channel-group index of current burst
wr_row output H_W row index of current burst
wr_last output 1 current burst is the final burst of the volume
done output 1 one-cycle pulse after final burst accepted (to reset_isOnOutput)
all_done output 1 sticky; set with done when latched last_volume=1

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters and latched registers 0.
- Reset is synchronous and applies mid-burst: wr_valid drops the next cycle and no done is produced.
- State IDLE:
  - start=1: latch all parameter inputs; row=0, cg=0; frame_base=frame_start; wr_addr=output_addr.
  - Go to ISSUE. wr_valid rises the cycle after start (latency 1).
- start while not IDLE is ignored. Upstream guarantees exclusion via isOnOutput.
- State ISSUE:
  - wr_valid=1.
  - wr_addr, wr_len, wr_cg, wr_row are held stable while wr_valid && !wr_ready.
  - A handshake is wr_valid && wr_ready. On each handshake:
    - row<buf_h1: row+1; wr_addr += addr_gap, zero-extended, modulo 2^ADDR_W.
    - row==buf_h1 and cg<idx_max: row=0; cg+1; frame_base += frame_size; wr_addr = new frame_base.
    - row==buf_h1 and cg==idx_max: go to DONE; wr_valid=0 the next cycle.
  - wr_last = (row==buf_h1) && (cg==idx_max), combinational from the counters.
- State DONE:
  - done=1 for exactly one cycle.
  - all_done set if latched last_volume.
  - Next state IDLE; busy low.
  - A start arriving in the DONE cycle is ignored. Earliest restart is the first IDLE cycle.
- all_done clears only on reset or on the next accepted start.
- Boundaries:
  - buf_h1=0 and idx_max=0: single burst with wr_last=1.
  - addr_gap=0 is legal: repeated address.
  - Address arithmetic wraps silently.
  - wr_ready may be held high continuously, giving back-to-back bursts at 1 per cycle.
- Burst count: (buf_h1+1)*(idx_max+1), times 2 when upsampling is active.

Optional Feature:
- Macro: CONV_OUT_UPSAMPLE_EN.
- Defined: do_upsample is latched with start. When the latched flag is 1:
  - Each row is issued twice: a second burst follows at wr_addr+addr_gap with identical wr_row and wr_cg.
  - The next row then starts at 2*addr_gap from the first copy.
  - wr_last is asserted only on the second copy of the final row.
- Not defined: do_upsample is ignored; one burst per row.

Test Plan:
1. Basic: output_addr=0x1000, frame_start=0x1000, buf_h1=2, idx_max=1, addr_gap=0x40, frame_size=0x400, out_w=16, wr_ready=1.
   -> bursts at 0x1000, 0x1040, 0x1080, 0x1400, 0x1440, 0x1480; wr_last only on 0x1480; done one cycle later; busy spans 7 cycles.
2. Backpressure: same stimulus as 1, wr_ready low 3 cycles on the 2nd burst -> wr_addr held at 0x1040 with wr_valid=1; sequence otherwise unchanged.
3. Single burst: buf_h1=0, idx_max=0 -> one burst with wr_last=1; done two cycles after start; start during busy produces no effect.
4. Last volume: start with last_volume=1 -> all_done rises with done and stays high; next start clears it.
5. Reset mid-operation: resetN low during the 3rd burst -> wr_valid, busy, done, all_done 0 next cycle; no done pulse; new start works normally.
6. Upsample (CONV_OUT_UPSAMPLE_EN, do_upsample=1): buf_h1=1, idx_max=0, addr_gap=0x40, output_addr=0x2000 -> bursts at 0x2000, 0x2040, 0x2080, 0x20C0; wr_row 0,0,1,1; wr_last on the 4th.

Source files
------------

// File: rtl/conv_out_writer_if.sv
// Write-burst request bus from conv_out_writer to the output memory port.
// The master drives the burst descriptor and valid. The slave returns ready.
interface conv_out_writer_if #(
  parameter int ADDR_W = 32,
  parameter int W_W    = 12,
  parameter int H_W    = 12,
  parameter int CG_W   = 8
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [W_W-1:0]    wr_len;
  logic [CG_W-1:0]   wr_cg;
  logic [H_W-1:0]    wr_row;
  logic              wr_last;

  modport master (
    output wr_valid, wr_addr, wr_len, wr_cg, wr_row, wr_last,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_addr, wr_len, wr_cg, wr_row, wr_last,
    output wr_ready
  );
endinterface

// File: rtl/conv_out_writer.sv
// conv_out_writer: consumer end of the convolution output-start handshake.
// Latches the output-volume parameters on start. It then issues one write
// burst per row: rows within a channel group first, then channel groups.
// It pulses done after the final burst is accepted.
// Optional row duplication is enabled by defining CONV_OUT_UPSAMPLE_EN.
module conv_out_writer #(
  parameter int ADDR_W  = 32,
  parameter int W_W     = 12,
  parameter int H_W     = 12,
  parameter int GAP_W   = 16,
  parameter int FRAME_W = 24,
  parameter int CG_W    = 8
) (
  input  logic               clock,
  input  logic               resetN,
  input  logic               start,
  input  logic               last_volume,
  input  logic [ADDR_W-1:0]  output_addr,
  input  logic [ADDR_W-1:0]  frame_start,
  input  logic [W_W-1:0]     out_w,
  input  logic [H_W-1:0]     buf_h1,
  input  logic [GAP_W-1:0]   addr_gap,
  input  logic [FRAME_W-1:0] frame_size,
  input  logic [CG_W-1:0]    idx_max,
  input  logic               do_upsample,
  output logic               busy,
  output logic               done,
  output logic               all_done,
  conv_out_writer_if.master  wr
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t             state;
  logic               valid_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  frame_base;
  logic [W_W-1:0]     len_q;
  logic [H_W-1:0]     row_q;
  logic [H_W-1:0]     h1_q;
  logic [CG_W-1:0]    cg_q;
  logic [CG_W-1:0]    idx_q;
  logic [GAP_W-1:0]   gap_q;
  logic [FRAME_W-1:0] fsize_q;
  logic               last_vol_q;

  logic               hs;
  logic               final_pos;
  logic               dup_step;
  logic [ADDR_W-1:0]  gap_ext;
  logic [ADDR_W-1:0]  fsize_ext;

  assign hs        = valid_q && wr.wr_ready;
  assign final_pos = (row_q == h1_q) && (cg_q == idx_q);
  assign gap_ext   = ADDR_W'(gap_q);
  assign fsize_ext = ADDR_W'(fsize_q);

`ifdef CONV_OUT_UPSAMPLE_EN
  logic ups_q;
  logic copy_q;

  // dup_step marks the first copy of a duplicated row.
  // The next handshake re-issues the same row one stride further on.
  assign dup_step = ups_q && !copy_q;

  // Track the upsample flag and which copy of the row is on the bus.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      ups_q  <= 1'b0;
      copy_q <= 1'b0;
    end else if (state == IDLE && start) begin
      ups_q  <= do_upsample;
      copy_q <= 1'b0;
    end else if (hs) begin
      copy_q <= dup_step;
    end
  end
`else
  logic unused_upsample;
  assign unused_upsample = do_upsample;
  assign dup_step        = 1'b0;
`endif

  assign wr.wr_valid = valid_q;
  assign wr.wr_addr  = addr_q;
  assign wr.wr_len   = len_q;
  assign wr.wr_cg    = cg_q;
  assign wr.wr_row   = row_q;
  // Gated by valid_q so that wr_last stays 0 while idle.
  // The counters hold their final values after a volume, which would otherwise match.
  assign wr.wr_last  = valid_q && final_pos && !dup_step;

  // Control FSM and address walk: row stride within a group, frame stride between groups.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      all_done   <= 1'b0;
      valid_q    <= 1'b0;
      addr_q     <= '0;
      frame_base <= '0;
      len_q      <= '0;
      row_q      <= '0;
      h1_q       <= '0;
      cg_q       <= '0;
      idx_q      <= '0;
      gap_q      <= '0;
      fsize_q    <= '0;
      last_vol_q <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            len_q      <= out_w;
            h1_q       <= buf_h1;
            idx_q      <= idx_max;
            gap_q      <= addr_gap;
            fsize_q    <= frame_size;
            last_vol_q <= last_volume;
            row_q      <= '0;
            cg_q       <= '0;
            frame_base <= frame_start;
            addr_q     <= output_addr;
            all_done   <= 1'b0;
            busy       <= 1'b1;
            valid_q    <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (hs) begin
            if (dup_step) begin
              addr_q <= addr_q + gap_ext;
            end else if (row_q != h1_q) begin
              row_q  <= row_q + H_W'(1);
              addr_q <= addr_q + gap_ext;
            end else if (cg_q != idx_q) begin
              row_q      <= '0;
              cg_q       <= cg_q + CG_W'(1);
              frame_base <= frame_base + fsize_ext;
              addr_q     <= frame_base + fsize_ext;
            end else begin
              valid_q <= 1'b0;
              done    <= 1'b1;
              if (last_vol_q) all_done <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_out_writer.sv
// Testbench for conv_out_writer.
// Expected bursts and done pulses are queued when each volume is launched.
// A negedge monitor pops and compares them as the DUT presents handshakes.
module tb_conv_out_writer;

  localparam int ADDR_W = 32, W_W = 12, H_W = 12, GAP_W = 16, FRAME_W = 24, CG_W = 8;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [W_W-1:0]    len;
    logic [CG_W-1:0]   cg;
    logic [H_W-1:0]    row;
    logic              last;
  } burst_t;

  logic               clock = 1'b0;
  logic               resetN = 1'b0;
  logic               start = 1'b0;
  logic               last_volume = 1'b0;
  logic [ADDR_W-1:0]  output_addr = '0;
  logic [ADDR_W-1:0]  frame_start = '0;
  logic [W_W-1:0]     out_w = '0;
  logic [H_W-1:0]     buf_h1 = '0;
  logic [GAP_W-1:0]   addr_gap = '0;
  logic [FRAME_W-1:0] frame_size = '0;
  logic [CG_W-1:0]    idx_max = '0;
  logic               do_upsample = 1'b0;
  logic               busy, done, all_done;

  int n_cmp = 0;
  int n_err = 0;

  burst_t sb[$];
  logic   done_q[$];

  conv_out_writer_if #(.ADDR_W(ADDR_W), .W_W(W_W), .H_W(H_W), .CG_W(CG_W)) bus ();

  conv_out_writer #(
    .ADDR_W(ADDR_W), .W_W(W_W), .H_W(H_W), .GAP_W(GAP_W), .FRAME_W(FRAME_W), .CG_W(CG_W)
  ) dut (
    .clock(clock), .resetN(resetN), .start(start), .last_volume(last_volume),
    .output_addr(output_addr), .frame_start(frame_start), .out_w(out_w),
    .buf_h1(buf_h1), .addr_gap(addr_gap), .frame_size(frame_size), .idx_max(idx_max),
    .do_upsample(do_upsample), .busy(busy), .done(done), .all_done(all_done),
    .wr(bus.master)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic [W_W-1:0] l,
                      input logic [CG_W-1:0] c, input logic [H_W-1:0] r, input logic last);
    burst_t b;
    b.addr = a; b.len = l; b.cg = c; b.row = r; b.last = last;
    sb.push_back(b);
  endtask

  task automatic set_params(input logic [ADDR_W-1:0] oa, input logic [ADDR_W-1:0] fs,
                            input logic [W_W-1:0] ow, input logic [H_W-1:0] h1,
                            input logic [GAP_W-1:0] gap, input logic [FRAME_W-1:0] fsz,
                            input logic [CG_W-1:0] idx, input logic lv, input logic ups);
    output_addr = oa; frame_start = fs; out_w = ow; buf_h1 = h1; addr_gap = gap;
    frame_size = fsz; idx_max = idx; last_volume = lv; do_upsample = ups;
  endtask

  // Monitor: scoreboard pops on handshakes and done pulses, plus a stall-hold check.
  logic              prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr;
  logic [H_W-1:0]    prev_row;
  logic [CG_W-1:0]   prev_cg;
  always @(negedge clock) begin
    burst_t b;
    logic   exp_ad;
    if (prev_stall) begin
      check("hold_valid", bus.wr_valid, 1);
      check("hold_addr", bus.wr_addr, prev_addr);
      check("hold_row", bus.wr_row, prev_row);
      check("hold_cg", bus.wr_cg, prev_cg);
    end
    prev_stall = bus.wr_valid && !bus.wr_ready && resetN;
    prev_addr  = bus.wr_addr;
    prev_row   = bus.wr_row;
    prev_cg    = bus.wr_cg;
    if (bus.wr_valid && bus.wr_ready) begin
      check("burst_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        b = sb.pop_front();
        check("wr_addr", bus.wr_addr, b.addr);
        check("wr_len", bus.wr_len, b.len);
        check("wr_cg", bus.wr_cg, b.cg);
        check("wr_row", bus.wr_row, b.row);
        check("wr_last", bus.wr_last, b.last);
      end
    end
    if (done) begin
      check("done_expected", done_q.size() != 0, 1);
      if (done_q.size() != 0) begin
        exp_ad = done_q.pop_front();
        check("all_done_with_done", all_done, exp_ad);
      end
    end
  end

  // Launch a volume (start held for 'hold' edges) and stall the stall_idx-th burst.
  task automatic run_volume(input int hold, input int stall_idx, input int stall_n,
                            output int busy_cycles);
    int acc = 0;
    int stalled = 0;
    bit seen = 0;
    busy_cycles = 0;
    @(posedge clock); #1; start = 1'b1;
    for (int cyc = 0; cyc < 300 && !seen; cyc++) begin
      @(posedge clock); #1;
      if (cyc + 1 >= hold) start = 1'b0;
      if (bus.wr_valid && acc == stall_idx && stalled < stall_n) begin
        bus.wr_ready = 1'b0; stalled++;
      end else begin
        bus.wr_ready = 1'b1;
      end
      @(negedge clock);
      if (bus.wr_valid && bus.wr_ready) acc++;
      if (busy) busy_cycles++;
      if (done) seen = 1;
    end
    check("done_seen", seen, 1);
    if (start) begin
      @(posedge clock); #1; start = 1'b0;
    end
  endtask

  initial begin
    int bc;
    bus.wr_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_all_done", all_done, 0);
    check("rst_valid", bus.wr_valid, 0);
    check("rst_last", bus.wr_last, 0);
    check("rst_addr", bus.wr_addr, 0);
    check("rst_len", bus.wr_len, 0);
    resetN = 1'b1;

    // 1: basic two-group walk, ready always high
    set_params(32'h1000, 32'h1000, 16, 2, 16'h40, 24'h400, 1, 0, 0);
    push(32'h1000, 16, 0, 0, 0); push(32'h1040, 16, 0, 1, 0); push(32'h1080, 16, 0, 2, 0);
    push(32'h1400, 16, 1, 0, 0); push(32'h1440, 16, 1, 1, 0); push(32'h1480, 16, 1, 2, 1);
    done_q.push_back(1'b0);
    run_volume(1, -1, 0, bc);
    check("t1_busy_cycles", bc, 7);

    // 2: same volume, 2nd burst stalled for 3 cycles
    push(32'h1000, 16, 0, 0, 0); push(32'h1040, 16, 0, 1, 0); push(32'h1080, 16, 0, 2, 0);
    push(32'h1400, 16, 1, 0, 0); push(32'h1440, 16, 1, 1, 0); push(32'h1480, 16, 1, 2, 1);
    done_q.push_back(1'b0);
    run_volume(1, 1, 3, bc);
    check("t2_busy_cycles", bc, 10);

    // 3: single burst; start held through ISSUE and DONE is ignored
    set_params(32'h3000, 32'h3000, 5, 0, 16'h40, 24'h400, 0, 0, 0);
    push(32'h3000, 5, 0, 0, 1);
    done_q.push_back(1'b0);
    run_volume(3, -1, 0, bc);
    check("t3_busy_cycles", bc, 2);
    repeat (2) @(posedge clock);
    #1;
    check("t3_idle_busy", busy, 0);
    check("t3_idle_valid", bus.wr_valid, 0);

    // 4: last volume, frame address wraps past 2^32
    set_params(32'hFFFF_FF10, 32'hFFFF_FF00, 8, 0, 16'h20, 24'h200, 1, 1, 0);
    push(32'hFFFF_FF10, 8, 0, 0, 0); push(32'h0000_0100, 8, 1, 0, 1);
    done_q.push_back(1'b1);
    run_volume(1, -1, 0, bc);
    repeat (3) @(posedge clock);
    #1;
    check("t4_all_done_sticky", all_done, 1);

    // 5: reset during the 3rd burst; next start clears all_done
    set_params(32'h1000, 32'h1000, 16, 2, 16'h40, 24'h400, 1, 0, 0);
    push(32'h1000, 16, 0, 0, 0); push(32'h1040, 16, 0, 1, 0);
    @(posedge clock); #1; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    check("t5_all_done_cleared", all_done, 0);
    check("t5_busy", busy, 1);
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("t5_third_addr", bus.wr_addr, 32'h1080);
    bus.wr_ready = 1'b0; resetN = 1'b0;
    @(posedge clock); #1;
    check("t5_rst_valid", bus.wr_valid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_all_done", all_done, 0);
    resetN = 1'b1; bus.wr_ready = 1'b1;
    repeat (4) @(posedge clock);
    set_params(32'h3000, 32'h3000, 5, 0, 16'h40, 24'h400, 0, 0, 0);
    push(32'h3000, 5, 0, 0, 1);
    done_q.push_back(1'b0);
    run_volume(1, -1, 0, bc);
    check("t5_restart_busy_cycles", bc, 2);

    // 6: upsample request (ignored unless the feature is built in)
    set_params(32'h2000, 32'h2000, 7, 1, 16'h40, 24'h400, 0, 0, 1);
`ifdef CONV_OUT_UPSAMPLE_EN
    push(32'h2000, 7, 0, 0, 0); push(32'h2040, 7, 0, 0, 0);
    push(32'h2080, 7, 0, 1, 0); push(32'h20C0, 7, 0, 1, 1);
    done_q.push_back(1'b0);
    run_volume(1, -1, 0, bc);
    check("t6_busy_cycles", bc, 5);
`else
    push(32'h2000, 7, 0, 0, 0); push(32'h2040, 7, 0, 1, 1);
    done_q.push_back(1'b0);
    run_volume(1, -1, 0, bc);
    check("t6_busy_cycles", bc, 3);
`endif

    // 7: zero row stride repeats the address
    set_params(32'h7000, 32'h7000, 3, 2, 16'h0, 24'h100, 0, 0, 0);
    push(32'h7000, 3, 0, 0, 0); push(32'h7000, 3, 0, 1, 0); push(32'h7000, 3, 0, 2, 1);
    done_q.push_back(1'b0);
    run_volume(1, 0, 2, bc);
    check("t7_busy_cycles", bc, 6);

    repeat (4) @(posedge clock);
    #1;
    check("sb_drained", sb.size(), 0);
    check("done_q_drained", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
